// File: rtl/state_dump_unit.sv
// Streams every register-file entry, then every data-memory entry, through a valid/ready output register.
// Define STATE_DUMP_CSUM_EN to append an XOR checksum word (tag 11) after the memory entries.
module state_dump_unit #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_rdata,
    output logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_tag,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG,
        S_MEM,
        S_CSUM,
        S_DONE
    } state_e;

    localparam logic [AW-1:0] IDX_LAST = '1;
    localparam logic [1:0]    TAG_REG  = 2'b00;
    localparam logic [1:0]    TAG_MEM  = 2'b01;
`ifdef STATE_DUMP_CSUM_EN
    localparam logic [1:0]    TAG_CSUM = 2'b11;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [1:0]    tag_q, tag_d;
    logic [AW-1:0] oidx_q, oidx_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
`ifdef STATE_DUMP_CSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif
    logic          free;

    // The output register may be overwritten when empty or when its word leaves this cycle.
    assign free = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        oidx_d  = oidx_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef STATE_DUMP_CSUM_EN
        csum_d  = csum_q;
`endif
        rf_addr = '0;
        dm_addr = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REG;
                    idx_d   = '0;
`ifdef STATE_DUMP_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_REG: begin
                rf_addr = idx_q;
                if (free) begin
                    valid_d = 1'b1;
                    tag_d   = TAG_REG;
                    oidx_d  = idx_q;
                    data_d  = rf_rdata;
                    idx_d   = idx_q + AW'(1);
`ifdef STATE_DUMP_CSUM_EN
                    csum_d  = csum_q ^ rf_rdata;
`endif
                    if (idx_q == IDX_LAST) begin
                        state_d = S_MEM;
                    end
                end
            end
            S_MEM: begin
                dm_addr = idx_q;
                if (free) begin
                    valid_d = 1'b1;
                    tag_d   = TAG_MEM;
                    oidx_d  = idx_q;
                    data_d  = dm_rdata;
                    idx_d   = idx_q + AW'(1);
`ifdef STATE_DUMP_CSUM_EN
                    csum_d  = csum_q ^ dm_rdata;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_CSUM;
                    end
`else
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CSUM: begin
`ifdef STATE_DUMP_CSUM_EN
                if (free) begin
                    valid_d = 1'b1;
                    tag_d   = TAG_CSUM;
                    oidx_d  = '0;
                    data_d  = csum_q;
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            oidx_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef STATE_DUMP_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            oidx_q  <= oidx_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef STATE_DUMP_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_tag   = tag_q;
    assign out_idx   = oidx_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Scoreboard bench for state_dump_unit: expected words are queued at start and popped on each accept.
module tb_state_dump_unit;

    localparam int unsigned AW     = 5;
    localparam int unsigned DW     = 32;
    localparam int unsigned N      = 1 << AW;
    localparam int          BUDGET = 1000;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_rdata;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_tag;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;

    logic [DW-1:0] rf [0:N-1];
    logic [DW-1:0] dm [0:N-1];
    logic [63:0]   sb_q [$];

    int n_checks;
    int n_errors;

    state_dump_unit #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rf_addr  (rf_addr),
        .rf_rdata (rf_rdata),
        .dm_addr  (dm_addr),
        .dm_rdata (dm_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_tag  (out_tag),
        .out_idx  (out_idx),
        .out_data (out_data)
    );

    assign rf_rdata = rf[rf_addr];
    assign dm_rdata = dm[dm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [1:0] t, input logic [AW-1:0] ix,
                                         input logic [DW-1:0] d);
        logic [63:0] r;
        r = '0;
        r[DW+AW+1:0] = {t, ix, d};
        return r;
    endfunction

    task automatic push_dump();
        logic [DW-1:0] cs;
        cs = '0;
        for (int i = 0; i < N; i++) begin
            sb_q.push_back(pack(2'b00, i[AW-1:0], rf[i]));
            cs ^= rf[i];
        end
        for (int i = 0; i < N; i++) begin
            sb_q.push_back(pack(2'b01, i[AW-1:0], dm[i]));
            cs ^= dm[i];
        end
`ifdef STATE_DUMP_CSUM_EN
        sb_q.push_back(pack(2'b11, '0, cs));
`endif
    endtask

    // mode 0: ready high, 1: ready toggles, 2: ready low for the first 10 valid cycles.
    // restart_idx re-pulses start after that RF word; abort_idx asserts reset while that DM word is shown.
    task automatic run_dump(input int mode, input int restart_idx, input int abort_idx);
        int          cyc;
        int          hold;
        bit          expect_done;
        bit          finished;
        bit          prev_hold;
        bit          restart_now;
        logic [63:0] prev_word;
        logic [63:0] cur_word;
        logic [63:0] exp_word;

        push_dump();
        cyc         = 0;
        hold        = 0;
        expect_done = 1'b0;
        finished    = 1'b0;
        prev_hold   = 1'b0;
        restart_now = 1'b0;
        prev_word   = '0;
        start       = 1'b1;
        while (!finished && cyc < BUDGET) begin
            case (mode)
                1:       out_ready = (cyc % 2 == 0);
                2:       out_ready = (hold >= 10);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            cur_word = {out_valid, 63'(pack(out_tag, out_idx, out_data))};
            if (expect_done) begin
                check_eq("done_pulse", done, 1);
                check_eq("busy_after_done", busy, 0);
                finished = 1'b1;
            end else begin
                if (done) check_eq("spurious_done", done, 0);
                if (prev_hold) check_eq("hold_stable", cur_word, prev_word);
                if (out_valid && !out_ready) hold++;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check_eq("extra_word", cur_word, 0);
                    end else begin
                        exp_word = sb_q.pop_front();
                        check_eq("word", pack(out_tag, out_idx, out_data), exp_word);
                        if (sb_q.size() == 0) expect_done = 1'b1;
                    end
                    if (restart_idx >= 0 && out_tag == 2'b00 && int'(out_idx) == restart_idx)
                        restart_now = 1'b1;
                end
                prev_hold = out_valid && !out_ready;
                prev_word = cur_word;
                if (abort_idx >= 0 && out_valid && out_tag == 2'b01 && int'(out_idx) == abort_idx) begin
                    reset = 1'b1;
                    #1;
                    check_eq("abort_valid", out_valid, 0);
                    check_eq("abort_busy", busy, 0);
                    check_eq("abort_done", done, 0);
                    check_eq("abort_addr", {rf_addr, dm_addr}, 0);
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check_eq("abort_no_done", done, 0);
                    end
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    sb_q.delete();
                    finished = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            start = restart_now;
            restart_now = 1'b0;
            cyc++;
        end
        start = 1'b0;
        if (!finished) check_eq("timeout", 0, 1);
        sb_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            rf[i] = DW'(i);
            dm[i] = DW'(32'h100 + i);
        end
        #3;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_out", pack(out_tag, out_idx, out_data), 0);
        check_eq("rst_addr", {rf_addr, dm_addr}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_dump(0, -1, -1);
        run_dump(1, -1, -1);
        run_dump(2, -1, -1);
        run_dump(0, -1, 7);
        run_dump(0, -1, -1);
        run_dump(0, 5, -1);

        for (int i = 0; i < N; i++) begin
            rf[i] = '1;
            dm[i] = '0;
        end
        run_dump(0, -1, -1);
        rf[3] = DW'(1);
        run_dump(1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
